path_replay: RTL and testbench

Reader at the far end of the direction stack in the maze solver. After the solver finishes, it drains the LIFO (last move first) into a local buffer, then replays the moves in original order on a valid/ready stream. It also tracks the resulting (x, y) cell. It sits between the direction stack and the path output/display logic.

---
 rtl/maze_pkg.sv | 33 +++
 rtl/path_buffer.sv | 33 +++
 rtl/path_replay.sv | 171 +++++++++++++++++
 tb/tb_path_replay.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
`default_nettype none
// ============================================================================
// Module      : maze_pkg
// Description : Shared types and default sizes for the maze path replay
//               slice: direction encoding, replay FSM states and defaults.
// Revision    : 1.0 - initial release
// ============================================================================
package maze_pkg;

  localparam int DIR_W_DEF   = 2;
  localparam int DEPTH_DEF   = 256;
  localparam int COORD_W_DEF = 4;

  // Move encoding shared with the direction stack
  typedef enum logic [DIR_W_DEF-1:0] {
    UP    = 2'd0,
    RIGHT = 2'd1,
    DOWN  = 2'd2,
    LEFT  = 2'd3
  } dir_t;

  // Replay controller states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CHECK   = 3'd1,
    ST_POP     = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_REPLAY  = 3'd4,
    ST_FINISH  = 3'd5
  } replay_state_t;

endpackage
`default_nettype wire

// File: rtl/path_buffer.sv
`default_nettype none
// ============================================================================
// Module      : path_buffer
// Description : DEPTH x DIR_W local store for drained moves. Synchronous
//               write, combinational read. Contents are not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module path_buffer #(
  parameter int DIR_W = 2,
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [DIR_W-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [DIR_W-1:0] rd_data
);

  logic [DIR_W-1:0] mem [DEPTH];

  // Capture one drained move per write strobe
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule
`default_nettype wire

// File: rtl/path_replay.sv
`default_nettype none
// ============================================================================
// Module      : path_replay
// Description : Drains the solver's direction LIFO into a local buffer, then
//               replays the moves oldest-first on a valid/ready stream while
//               tracking the resulting (x, y) cell.
//               Build option: PATH_REPLAY_COORD_EN compiles in the coordinate
//               tracker; without it x_out/y_out are tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module path_replay
  import maze_pkg::*;
#(
  parameter int DIR_W   = DIR_W_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int COORD_W = COORD_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               stk_pop,
  input  logic [DIR_W-1:0]   stk_data,
  input  logic               stk_empty,
  output logic [DIR_W-1:0]   dir_out,
  output logic               dir_valid,
  input  logic               dir_ready,
  output logic [COORD_W-1:0] x_out,
  output logic [COORD_W-1:0] y_out,
  output logic               busy,
  output logic               done,
  output logic               overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  replay_state_t    state;
  replay_state_t    state_nxt;
  logic [CW-1:0]    cnt;
  logic [AW-1:0]    idx;
  logic             ovf;
  logic             buf_wr;
  logic             xfer;
  logic             launch;
  logic [DIR_W-1:0] rd_data;

  // Local copy of the drained path; slot 0 holds the most recent move
  path_buffer #(
    .DIR_W (DIR_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .wr_en   (buf_wr),
    .wr_addr (cnt[AW-1:0]),
    .wr_data (stk_data),
    .rd_addr (idx),
    .rd_data (rd_data)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and Moore-style strobes
  always_comb begin
    state_nxt = state;
    stk_pop   = 1'b0;
    dir_valid = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    buf_wr    = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = ST_CHECK;
      end
      ST_CHECK: begin
        // Stop draining on an empty stack or a full buffer
        if (stk_empty || (cnt == FULL)) state_nxt = ST_REPLAY;
        else                            state_nxt = ST_POP;
      end
      ST_POP: begin
        stk_pop   = 1'b1;
        state_nxt = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        buf_wr    = 1'b1;
        state_nxt = ST_CHECK;
      end
      ST_REPLAY: begin
        if (cnt == '0) begin
          state_nxt = ST_FINISH;
        end else begin
          dir_valid = 1'b1;
          if (dir_ready && (idx == '0)) state_nxt = ST_FINISH;
        end
      end
      ST_FINISH: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign launch   = (state == ST_IDLE) && start;
  assign xfer     = dir_valid && dir_ready;
  // Buffer read is only meaningful while presenting a move
  assign dir_out  = dir_valid ? rd_data : '0;
  assign overflow = ovf;

  // Fill count, replay index and sticky overflow flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
      ovf <= 1'b0;
    end else if (launch) begin
      cnt <= '0;
      idx <= '0;
      ovf <= 1'b0;
    end else begin
      if ((state == ST_CHECK) && !stk_empty && (cnt == FULL)) ovf <= 1'b1;
      if (buf_wr) begin
        cnt <= cnt + 1'b1;
        // idx tracks the newest slot so replay starts at cnt-1
        idx <= cnt[AW-1:0];
      end
      if (xfer && (idx != '0)) idx <= idx - 1'b1;
    end
  end

`ifdef PATH_REPLAY_COORD_EN
  logic [COORD_W-1:0] pos_x;
  logic [COORD_W-1:0] pos_y;

  // Apply each accepted move to the position, wrapping modulo 2^COORD_W
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_x <= '0;
      pos_y <= '0;
    end else if (launch) begin
      pos_x <= '0;
      pos_y <= '0;
    end else if (xfer) begin
      case (dir_t'(rd_data[1:0]))
        UP:      pos_y <= pos_y + 1'b1;
        RIGHT:   pos_x <= pos_x + 1'b1;
        DOWN:    pos_y <= pos_y - 1'b1;
        LEFT:    pos_x <= pos_x - 1'b1;
        default: pos_x <= pos_x;
      endcase
    end
  end

  assign x_out = pos_x;
  assign y_out = pos_y;
`else
  assign x_out = '0;
  assign y_out = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_path_replay.sv
`default_nettype none
// ============================================================================
// Module      : tb_path_replay
// Description : Directed bench for path_replay (DEPTH=4) with a LIFO stack
//               model and an expected-direction queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_path_replay;

  localparam int DEPTH = 4;
`ifdef PATH_REPLAY_COORD_EN
  localparam bit COORD_EN = 1'b1;
`else
  localparam bit COORD_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       stk_pop;
  logic [1:0] stk_data;
  logic       stk_empty;
  logic [1:0] dir_out;
  logic       dir_valid;
  logic       dir_ready;
  logic [3:0] x_out;
  logic [3:0] y_out;
  logic       busy;
  logic       done;
  logic       overflow;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         pop_cnt;
  logic [1:0] path[$];
  logic [1:0] exp_q[$];
  logic [1:0] stk[$];
  logic [3:0] ex_x;
  logic [3:0] ex_y;

  path_replay #(.DIR_W(2), .DEPTH(DEPTH), .COORD_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stk_pop   (stk_pop),
    .stk_data  (stk_data),
    .stk_empty (stk_empty),
    .dir_out   (dir_out),
    .dir_valid (dir_valid),
    .dir_ready (dir_ready),
    .x_out     (x_out),
    .y_out     (y_out),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: score transfers before the edge, then update the stack model
  task automatic tick();
    logic popped;
    @(negedge clk);
    popped = stk_pop;
    if (stk_pop) pop_cnt++;
    if (dir_valid && dir_ready) begin
      if (exp_q.size() == 0) check("extra_dir", 32'd1, 32'd0);
      else                   check("dir", dir_out, exp_q.pop_front());
    end
    @(posedge clk);
    #1;
    if (popped) begin
      if (stk.size() > 0) stk_data = stk.pop_back();
      else                stk_data = 2'd0;
    end
    stk_empty = (stk.size() == 0);
  endtask

  // Push path onto the stack; the replayable tail goes to the scoreboard
  task automatic load();
    int first;
    ex_x  = 4'd0;
    ex_y  = 4'd0;
    first = (path.size() > DEPTH) ? path.size() - DEPTH : 0;
    for (int i = 0; i < path.size(); i++) begin
      stk.push_back(path[i]);
      if (i >= first) begin
        exp_q.push_back(path[i]);
        case (path[i])
          2'd0: ex_y = ex_y + 4'd1;
          2'd1: ex_x = ex_x + 4'd1;
          2'd2: ex_y = ex_y - 4'd1;
          default: ex_x = ex_x - 4'd1;
        endcase
      end
    end
    stk_empty = (stk.size() == 0);
  endtask

  task automatic kick();
    pop_cnt = 0;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int cyc;
    cyc = 0;
    while (!done && cyc < 200) begin
      tick();
      cyc++;
    end
    check({tag, "_done"}, done, 1'b1);
  endtask

  task automatic wait_valid(input string tag);
    int cyc;
    cyc = 0;
    while (!dir_valid && cyc < 100) begin
      tick();
      cyc++;
    end
    check({tag, "_valid"}, dir_valid, 1'b1);
  endtask

  task automatic check_pos(input string tag);
    check({tag, "_x"}, x_out, COORD_EN ? ex_x : 4'd0);
    check({tag, "_y"}, y_out, COORD_EN ? ex_y : 4'd0);
  endtask

  // Directed sequence
  initial begin
    rst = 1'b1; start = 1'b0; dir_ready = 1'b0;
    stk_data = 2'd0; stk_empty = 1'b1; pop_cnt = 0;
    tick(); tick();
    check("rst_pop", stk_pop, 1'b0);
    check("rst_valid", dir_valid, 1'b0);
    check("rst_dir", dir_out, 2'd0);
    check("rst_x", x_out, 4'd0);
    check("rst_y", y_out, 4'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ovf", overflow, 1'b0);
    rst = 1'b0;
    tick();

    // Empty stack: CHECK, REPLAY, FINISH
    dir_ready = 1'b1;
    kick();
    check("empty_c1_busy", busy, 1'b1);
    check("empty_c1_done", done, 1'b0);
    tick();
    check("empty_c2_done", done, 1'b0);
    check("empty_c2_valid", dir_valid, 1'b0);
    tick();
    check("empty_c3_done", done, 1'b1);
    check("empty_c3_valid", dir_valid, 1'b0);
    tick();
    check("empty_idle_busy", busy, 1'b0);
    check("empty_x", x_out, 4'd0);
    check("empty_y", y_out, 4'd0);

    // Basic path fits the buffer exactly
    path = {2'd0, 2'd1, 2'd1, 2'd2};
    load();
    kick();
    wait_done("basic");
    check("basic_pops", pop_cnt, 4);
    check("basic_left", exp_q.size(), 0);
    check("basic_ovf", overflow, 1'b0);
    check_pos("basic");
    tick();
    check("basic_done_pulse", done, 1'b0);
    check("basic_busy_off", busy, 1'b0);

    // Backpressure mid-replay
    path = {2'd0, 2'd3, 2'd3, 2'd2};
    dir_ready = 1'b0;
    load();
    kick();
    wait_valid("stall");
    check("stall_head", dir_out, 2'd0);
    dir_ready = 1'b1;
    tick();
    dir_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("stall_valid", dir_valid, 1'b1);
      check("stall_dir", dir_out, 2'd3);
      check("stall_x", x_out, 4'd0);
      check("stall_y", y_out, COORD_EN ? 4'd1 : 4'd0);
      tick();
    end
    dir_ready = 1'b1;
    wait_done("stall");
    check("stall_left", exp_q.size(), 0);
    check_pos("stall");
    tick();

    // Single LEFT wraps x below zero
    path = {2'd3};
    load();
    kick();
    wait_done("left");
    check_pos("left");
    tick();

    // Six moves into a four-entry buffer
    path = {2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd1};
    load();
    kick();
    wait_done("ovf");
    check("ovf_flag", overflow, 1'b1);
    check("ovf_pops", pop_cnt, 4);
    check("ovf_stack_left", stk.size(), 2);
    check("ovf_left", exp_q.size(), 0);
    check_pos("ovf");
    tick();
    check("ovf_sticky", overflow, 1'b1);
    stk.delete();
    stk_empty = 1'b1;

    // Reset during replay, then restart with a start pulse while busy
    path = {2'd0, 2'd1, 2'd2, 2'd3};
    dir_ready = 1'b0;
    load();
    kick();
    check("ovf_cleared", overflow, 1'b0);
    wait_valid("rr");
    rst = 1'b1;
    #1;
    check("rr_busy", busy, 1'b0);
    check("rr_valid", dir_valid, 1'b0);
    tick();
    rst = 1'b0;
    exp_q.delete();
    stk.delete();
    stk_empty = 1'b1;
    dir_ready = 1'b1;
    path = {2'd1, 2'd0};
    load();
    kick();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("rr");
    check("rr_pops", pop_cnt, 2);
    check("rr_left", exp_q.size(), 0);
    check_pos("rr");
    tick();
    check("rr_idle", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
